// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes,
// operand width and predictor helpers.
package branch_resolve_unit_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int BRANCH_COND_LENGTH = 3;

  typedef logic [BRANCH_COND_LENGTH-1:0] branch_cond_t;

  // RV32I funct3 encodings; codes 3'b010 and 3'b011 are not branches.
  localparam branch_cond_t BRANCH_COND_EQ  = 3'b000;
  localparam branch_cond_t BRANCH_COND_NE  = 3'b001;
  localparam branch_cond_t BRANCH_COND_LT  = 3'b100;
  localparam branch_cond_t BRANCH_COND_GE  = 3'b101;
  localparam branch_cond_t BRANCH_COND_LTU = 3'b110;
  localparam branch_cond_t BRANCH_COND_GEU = 3'b111;

  // Weakly not-taken: the state every predictor counter starts in.
  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic is_branch(input branch_cond_t op);
    return op inside {BRANCH_COND_EQ, BRANCH_COND_NE, BRANCH_COND_LT,
                      BRANCH_COND_GE, BRANCH_COND_LTU, BRANCH_COND_GEU};
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle between the pipeline (master) and
// the branch resolve unit (slave).
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = branch_resolve_unit_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 32
);
  import branch_resolve_unit_pkg::branch_cond_t;

  logic                  in_valid;
  logic                  in_ready;
  branch_cond_t          branch_op;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] imm;
  logic                  pred_taken;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_taken;
  logic                  out_mispredict;
  logic [ADDR_WIDTH-1:0] out_redirect_pc;

  modport master (
    output in_valid, branch_op, rs1, rs2, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc
  );

  modport slave (
    input  in_valid, branch_op, rs1, rs2, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Purely combinational RV32I branch condition evaluator.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_WIDTH = branch_resolve_unit_pkg::DATA_WIDTH
) (
  input  branch_cond_t          op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  taken
);

  // Evaluate the condition; unknown codes resolve as not taken.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    taken = 1'b0;
    case (op)
      BRANCH_COND_EQ:  taken = (rs1 == rs2);
      BRANCH_COND_NE:  taken = (rs1 != rs2);
      BRANCH_COND_LT:  taken = ($signed(rs1) <  $signed(rs2));
      BRANCH_COND_GE:  taken = ($signed(rs1) >= $signed(rs2));
      BRANCH_COND_LTU: taken = (rs1 <  rs2);
      BRANCH_COND_GEU: taken = (rs1 >= rs2);
      default:         taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves one branch per cycle: evaluates the condition, computes the
// redirect target, flags mispredictions, trains a 2-bit BHT and keeps
// performance counters. Result is registered with a valid/ready handshake.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_WIDTH = branch_resolve_unit_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_taken,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic                  in_ready;
  logic                  fire;
  logic                  cmp_taken;
  logic                  cmp_mispredict;
  logic [IDX_W-1:0]      upd_idx;
  logic [IDX_W-1:0]      lookup_idx;

  logic                  out_valid_q,       out_valid_d;
  logic                  out_taken_q,       out_taken_d;
  logic                  out_mispredict_q,  out_mispredict_d;
  logic [ADDR_WIDTH-1:0] out_redirect_pc_q, out_redirect_pc_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q,      branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_q,  mispredict_cnt_d;
  logic [1:0]            bht_q [BHT_DEPTH];
  logic [1:0]            bht_d [BHT_DEPTH];

  branch_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .op    (bus.branch_op),
    .rs1   (bus.rs1),
    .rs2   (bus.rs2),
    .taken (cmp_taken)
  );

  // Handshake, predictor indices and the read-before-write lookup port.
  always_comb begin
    in_ready       = (!out_valid_q || bus.out_ready) && !flush;
    fire           = bus.in_valid && in_ready;
    cmp_mispredict = cmp_taken ^ bus.pred_taken;
    upd_idx        = bus.pc[IDX_W+1:2];
    lookup_idx     = lookup_pc[IDX_W+1:2];
    lookup_taken   = bht_q[lookup_idx][1];
  end

  // Result register next-state: load on fire, drop on consume or flush.
  always_comb begin
    out_valid_d       = out_valid_q;
    out_taken_d       = out_taken_q;
    out_mispredict_d  = out_mispredict_q;
    out_redirect_pc_d = out_redirect_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d       = 1'b1;
      out_taken_d       = cmp_taken;
      out_mispredict_d  = cmp_mispredict;
      out_redirect_pc_d = cmp_taken ? bus.pc + bus.imm : bus.pc + ADDR_WIDTH'(4);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Predictor training and counters advance only for real branches that fire.
  always_comb begin
    bht_d            = bht_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (fire && is_branch(bus.branch_op)) begin
      bht_d[upd_idx] = sat_update(bht_q[upd_idx], cmp_taken);
      branch_cnt_d   = branch_cnt_q + CNT_WIDTH'(1);
      if (cmp_mispredict) mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset drops any held result and re-initialises the BHT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      out_valid_q       <= 1'b0;
      out_taken_q       <= 1'b0;
      out_mispredict_q  <= 1'b0;
      out_redirect_pc_q <= '0;
      branch_cnt_q      <= '0;
      mispredict_cnt_q  <= '0;
      // NOTE: the BHT is a flop array, not a RAM, so every entry can take a known reset value.
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else begin
      out_valid_q       <= out_valid_d;
      out_taken_q       <= out_taken_d;
      out_mispredict_q  <= out_mispredict_d;
      out_redirect_pc_q <= out_redirect_pc_d;
      branch_cnt_q      <= branch_cnt_d;
      mispredict_cnt_q  <= mispredict_cnt_d;
      bht_q             <= bht_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_taken       = out_taken_q;
  assign bus.out_mispredict  = out_mispredict_q;
  assign bus.out_redirect_pc = out_redirect_pc_q;
  assign branch_cnt          = branch_cnt_q;
  assign mispredict_cnt      = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of single-branch vectors
// applied back to back, plus sequences for reset, predictor training,
// back-pressure and flush.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [AW-1:0] lookup_pc;
  logic          lookup_taken;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_br  = 0;
  int exp_mis = 0;

  branch_resolve_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  branch_resolve_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (lookup_taken),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    branch_cond_t  op;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [AW-1:0] pc;
    logic [AW-1:0] imm;
    logic          pred;
    logic          exp_taken;
    logic [AW-1:0] exp_redirect;
    logic          exp_mis;
    logic          is_br;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input branch_cond_t op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] pc, input logic [AW-1:0] imm, input logic pred);
    bus.in_valid   = 1'b1;
    bus.branch_op  = op;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.pred_taken = pred;
  endtask

  task automatic check_result(input string tag, input logic taken, input logic [AW-1:0] redir,
                              input logic mis);
    check({tag, "_valid"},    64'(bus.out_valid),       64'd1);
    check({tag, "_taken"},    64'(bus.out_taken),       64'(taken));
    check({tag, "_redirect"}, 64'(bus.out_redirect_pc), 64'(redir));
    check({tag, "_mispred"},  64'(bus.out_mispredict),  64'(mis));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_branch_cnt"}, 64'(branch_cnt),     64'(exp_br));
    check({tag, "_mis_cnt"},    64'(mispredict_cnt), 64'(exp_mis));
  endtask

  task automatic check_reset_state(input string tag);
    logic all_init;
    all_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (dut.bht_q[i] !== 2'b01) all_init = 1'b0;
    check({tag, "_out_valid"}, 64'(bus.out_valid),       64'd0);
    check({tag, "_taken"},     64'(bus.out_taken),       64'd0);
    check({tag, "_mispred"},   64'(bus.out_mispredict),  64'd0);
    check({tag, "_redirect"},  64'(bus.out_redirect_pc), 64'd0);
    check({tag, "_bht_all01"}, 64'(all_init),            64'd1);
    exp_br  = 0;
    exp_mis = 0;
    check_counters(tag);
  endtask

  initial begin
    // Table: op, rs1, rs2, pc, imm, pred -> taken, redirect, mispredict, is_branch.
    // PCs avoid BHT index 0 so the training sequences there stay undisturbed.
    vecs[0] = '{BRANCH_COND_EQ,  32'd5, 32'd5, 32'h204, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h1FC, 1'b0, 1'b1};
    vecs[1] = '{BRANCH_COND_NE,  32'd5, 32'd5, 32'h208, 32'h40, 1'b1, 1'b0, 32'h20C, 1'b1, 1'b1};
    vecs[2] = '{BRANCH_COND_GE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h30C, 32'h10, 1'b0, 1'b0, 32'h310, 1'b0, 1'b1};
    vecs[3] = '{BRANCH_COND_GEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h30C, 32'h10, 1'b0, 1'b1, 32'h31C, 1'b1, 1'b1};
    vecs[4] = '{BRANCH_COND_LT,  32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'h404, 32'h100, 1'b1, 1'b1, 32'h504, 1'b0, 1'b1};
    vecs[5] = '{BRANCH_COND_GE,  32'd7, 32'd7, 32'h408, 32'h8, 1'b1, 1'b1, 32'h410, 1'b0, 1'b1};
    vecs[6] = '{3'b010,          32'd0, 32'd0, 32'h504, 32'h20, 1'b1, 1'b0, 32'h508, 1'b1, 1'b0};
    vecs[7] = '{3'b011,          32'd0, 32'd0, 32'h508, 32'h20, 1'b0, 1'b0, 32'h50C, 1'b0, 1'b0};
    vecs[8] = '{BRANCH_COND_LTU, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1};
    vecs[9] = '{BRANCH_COND_LTU, 32'd2, 32'd1, 32'h10, 32'h20, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1};

    rst_n = 1'b1;
    flush = 1'b0;
    lookup_pc = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(BRANCH_COND_EQ, '0, '0, '0, '0, 1'b0);
    bus.in_valid = 1'b0;

    // Power-on reset.
    #2 rst_n = 1'b0;
    #10;
    check_reset_state("por");
    check("por_in_ready", 64'(bus.in_ready), 64'd1);
    check("por_lookup", 64'(lookup_taken), 64'd0);
    rst_n = 1'b1;
    tick();

    // Signed BLT: -1 < 1 taken, predicted not taken.
    lookup_pc = 32'h8000_0000;
    drive(BRANCH_COND_LT, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h10, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    exp_br = 1; exp_mis = 1;
    check_result("blt", 1'b1, 32'h8000_0010, 1'b1);
    check_counters("blt");

    // Reset in the middle of a held result: everything drops at once.
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Unsigned BLTU with the same operands: not taken, counter 01 -> 00.
    drive(BRANCH_COND_LTU, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h10, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    exp_br = 1;
    check_result("bltu", 1'b0, 32'h8000_0004, 1'b0);
    check_counters("bltu");
    check("bltu_bht0", 64'(dut.bht_q[0]), 64'd0);

    // Four taken BEQ at 0x100 (index 0): 00 -> 01 -> 10 -> 11 -> 11.
    lookup_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("beq%0d_lookup_before", i), 64'(lookup_taken), (i >= 2) ? 64'd1 : 64'd0);
      drive(BRANCH_COND_EQ, 32'd9, 32'd9, 32'h100, 32'h40, 1'b1);
      tick();
      exp_br++;
      check($sformatf("beq%0d_lookup_after", i), 64'(lookup_taken), (i >= 1) ? 64'd1 : 64'd0);
    end
    bus.in_valid = 1'b0;
    check_result("beq4", 1'b1, 32'h140, 1'b0);
    check("beq4_bht0_sat", 64'(dut.bht_q[0]), 64'd3);
    check_counters("beq4");

    // Table vectors back to back with out_ready high: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      tick();
      if (vecs[i].is_br) begin
        exp_br++;
        if (vecs[i].exp_mis) exp_mis++;
      end
      check_result($sformatf("vec%0d", i), vecs[i].exp_taken, vecs[i].exp_redirect, vecs[i].exp_mis);
      check_counters($sformatf("vec%0d", i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("table_drain_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: result held for three cycles, second request waits.
    bus.out_ready = 1'b0;
    drive(BRANCH_COND_NE, 32'd1, 32'd2, 32'h604, 32'h40, 1'b1);
    tick();
    exp_br++;
    drive(BRANCH_COND_EQ, 32'd1, 32'd2, 32'h708, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
      check_result($sformatf("bp%0d", i), 1'b1, 32'h644, 1'b0);
      check_counters($sformatf("bp%0d", i));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    exp_br++; exp_mis++;
    check_result("bp_second", 1'b0, 32'h70C, 1'b1);
    check_counters("bp_second");
    tick();
    check("bp_drain_valid", 64'(bus.out_valid), 64'd0);

    // Flush with a held result and a same-cycle request.
    bus.out_ready = 1'b0;
    drive(BRANCH_COND_EQ, 32'd3, 32'd3, 32'h800, 32'h10, 1'b0);
    tick();
    exp_br++; exp_mis++;
    check_result("pre_flush", 1'b1, 32'h810, 1'b1);
    drive(BRANCH_COND_NE, 32'd3, 32'd3, 32'h800, 32'h10, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_bht0", 64'(dut.bht_q[0]), 64'd3);
    check_counters("flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-003 SHALL have parameter BHT_DEPTH, default 64, power of two >= 2, number of 2-bit predictor counters.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, performance counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  branch request valid.
REQ-008 in_ready  out  1  unit can accept request.
REQ-009 branch_op  in  BRANCH_COND_LENGTH  condition code: EQ, NE, LT, GE, LTU, GEU; any other code = not a branch.
REQ-010 rs1, rs2  in  DATA_WIDTH each  compare operands.
REQ-011 pc, imm  in  ADDR_WIDTH each  branch PC and sign-extended offset.
REQ-012 pred_taken  in  1  prediction used by fetch for this branch.
REQ-013 flush  in  1  discard held result and any same-cycle request.
REQ-014 lookup_pc  in  ADDR_WIDTH; lookup_taken  out  1  combinational predictor read for fetch.
REQ-015 out_valid  in/out: out_valid out 1, out_ready in 1  result handshake.
REQ-016 out_taken, out_mispredict  out  1 each; out_redirect_pc  out  ADDR_WIDTH.
REQ-017 branch_cnt, mispredict_cnt  out  CNT_WIDTH each  performance counters.

Function
REQ-018 Comparison SHALL match RV32I semantics: EQ/NE equality, LT/GE signed, LTU/GEU unsigned, over DATA_WIDTH bits; non-branch codes give taken=0.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-020 A request fires when in_valid && in_ready; result registers load on that edge, giving latency of exactly 1 cycle to out_valid.
REQ-021 out_redirect_pc SHALL be pc+imm when taken, else pc+4, both modulo 2^ADDR_WIDTH.
REQ-022 out_mispredict SHALL be taken XOR pred_taken.
REQ-023 out_valid SHALL hold with stable outputs until out_ready; clears on out_ready without a new fire.
REQ-024 Back-to-back fire with out_ready=1 SHALL sustain one result per cycle.
REQ-025 flush SHALL clear out_valid on the next edge, block the same-cycle fire, and suppress its BHT and counter updates.
REQ-026 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2]; lookup index same bits of lookup_pc.
REQ-027 lookup_taken SHALL be MSB of the indexed counter, read-before-write when index equals the updating one.
REQ-028 On fire with valid branch code, counter SHALL increment (taken) or decrement (not taken), saturating at 3 and 0.
REQ-029 Non-branch codes SHALL fire and produce output but SHALL NOT update BHT or counters.
REQ-030 On valid-branch fire, branch_cnt SHALL +1 and mispredict_cnt SHALL +1 if mispredict; both wrap at 2^CNT_WIDTH.

Reset
REQ-031 rst_n low SHALL immediately clear out_valid, out_taken, out_mispredict, out_redirect_pc, branch_cnt, mispredict_cnt to 0.
REQ-032 rst_n low SHALL set every BHT counter to 2'b01 (weakly not-taken).
REQ-033 Reset asserted mid-transaction SHALL drop the held result; no partial update survives.

Structure
REQ-034 BRANCH_COND_* codes, BRANCH_COND_LENGTH and DATA_WIDTH SHALL come from the shared define.vh package.
REQ-035 The comparator SHALL be one combinational sub-module, branch_cmp, parametrised by DATA_WIDTH.
REQ-036 BHT SHALL be a flop array inside branch_resolve_unit; no other sub-modules.

Verification
REQ-037 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x80000000, imm=0x10, pred=0 -> next cycle out_taken=1, redirect=0x80000010, mispredict=1, mispredict_cnt=1.
REQ-038 BLTU same operands, pred=0 -> taken=0, redirect=0x80000004, mispredict=0; BHT counter at index 0 goes 01->00.
REQ-039 Four taken BEQ at pc=0x100 -> lookup_taken(0x100) becomes 1 after second, counter saturates at 3; branch_cnt=4.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, one result only, no extra counter increments.
REQ-041 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, BHT and counters unchanged.
REQ-042 pc=0xFFFFFFF0, imm=0x20, taken -> redirect=0x00000010; rst_n low mid-stream -> out_valid=0 at once, all counters 01.
